// File: rtl/updown_counter_n_if.sv
// rtl/updown_counter_n_if.sv - control/status bundle for updown_counter_n
//
// Purpose: groups the counter's control inputs and registered outputs so the
// lab top level can pass the whole counter port set as a single connection.
//
// Signals:
//   i_en        count enable; 0 means no step occurs
//   i_updown    direction: 1 = up, 0 = down
//   i_load      synchronous parallel load request
//   i_load_val  value to load (clamped to MAX_VAL inside the counter)
//   i_sat_mode  overflow mode: 0 = wrap, 1 = saturate
//   o_count     current count
//   o_tc        terminal-count pulse, one cycle wide
//   o_seg       direction glyph, active-low, o_seg[1..7] = segments a..g
//   o_dp        saturation indicator, active-low
//
// Modports:
//   master  drives the controls and observes the outputs (board / bench side)
//   slave   the counter itself

interface updown_counter_n_if #(
   parameter int WIDTH = 4
);
   logic             i_en;
   logic             i_updown;
   logic             i_load;
   logic [WIDTH-1:0] i_load_val;
   logic             i_sat_mode;
   logic [WIDTH-1:0] o_count;
   logic             o_tc;
   logic [7:1]       o_seg;
   logic             o_dp;

   modport master (
      output i_en,
      output i_updown,
      output i_load,
      output i_load_val,
      output i_sat_mode,
      input  o_count,
      input  o_tc,
      input  o_seg,
      input  o_dp
   );

   modport slave (
      input  i_en,
      input  i_updown,
      input  i_load,
      input  i_load_val,
      input  i_sat_mode,
      output o_count,
      output o_tc,
      output o_seg,
      output o_dp
   );
endinterface

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - modulus-programmable up/down counter with load, wrap/saturate and direction glyph
//
// Purpose: counts 0..MAX_VAL up or down under an enable, with a synchronous
// parallel load (clamped to MAX_VAL), wrap or saturate behaviour at the ends,
// a one-cycle terminal-count pulse on every wrap, an active-low saturation
// indicator, and a registered 7-segment glyph ("U" / "d") showing direction.
// Every output is a flop; nothing passes combinationally from input to output.
//
// Parameters:
//   WIDTH    counter width in bits, 2..16
//   MAX_VAL  highest count value, 1..2**WIDTH-1
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-low
//   bus    slave modport of updown_counter_n_if (controls in, status out)

module updown_counter_n #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = (1 << WIDTH) - 1
) (
   input  logic                clock,
   input  logic                reset,
   updown_counter_n_if.slave   bus
);

   localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] C_ZERO = '0;
   localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

   // Active-low glyphs, bit order g..a
   localparam logic [7:1] C_SEG_UP   = 7'b1000001;  // "U": b,c,d,e,f lit
   localparam logic [7:1] C_SEG_DOWN = 7'b0100001;  // "d": b,c,d,e,g lit

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_dp;
   logic [7:1]       r_seg;

   logic             w_at_max;
   logic             w_at_zero;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_count_next;
   logic             w_tc_next;
   logic             w_dp_next;
   logic [7:1]       w_seg_next;

   // Boundaries are against MAX_VAL, not the all-ones value of the register,
   // so a modulus such as 10 on a 4-bit counter behaves correctly.
   assign w_at_max  = (r_count >= C_MAX);
   assign w_at_zero = (r_count == C_ZERO);

   // load_val fits WIDTH bits, so the clamp needs only a compare against MAX
   assign w_load_clamped = (bus.i_load_val > C_MAX) ? C_MAX : bus.i_load_val;

   // The glyph tracks direction every cycle, regardless of load or enable
   assign w_seg_next = bus.i_updown ? C_SEG_UP : C_SEG_DOWN;

   // Next-state for count/tc/dp in load > step > hold order. tc defaults low
   // so it can only ever be a single-cycle pulse after a wrap edge.
   always_comb begin
      w_count_next = r_count;
      w_tc_next    = 1'b0;
      w_dp_next    = r_dp;

      if (bus.i_load) begin
         w_count_next = w_load_clamped;
         w_dp_next    = 1'b1;
      end else if (bus.i_en) begin
         if (bus.i_updown) begin
            if (!w_at_max) begin
               w_count_next = r_count + C_ONE;
               w_dp_next    = 1'b1;
            end else if (!bus.i_sat_mode) begin
               w_count_next = C_ZERO;
               w_tc_next    = 1'b1;
               w_dp_next    = 1'b1;
            end else begin
               // blocked step: count holds, indicator lights
               w_dp_next    = 1'b0;
            end
         end else begin
            if (!w_at_zero) begin
               w_count_next = r_count - C_ONE;
               w_dp_next    = 1'b1;
            end else if (!bus.i_sat_mode) begin
               w_count_next = C_MAX;
               w_tc_next    = 1'b1;
               w_dp_next    = 1'b1;
            end else begin
               w_dp_next    = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_count <= C_ZERO;
         r_tc    <= 1'b0;
         r_dp    <= 1'b1;
         r_seg   <= C_SEG_UP;
      end else begin
         r_count <= w_count_next;
         r_tc    <= w_tc_next;
         r_dp    <= w_dp_next;
         r_seg   <= w_seg_next;
      end
   end

   assign bus.o_count = r_count;
   assign bus.o_tc    = r_tc;
   assign bus.o_dp    = r_dp;
   assign bus.o_seg   = r_seg;

endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - directed self-checking bench for updown_counter_n

module tb_updown_counter_n;

   localparam logic [7:1] SEG_U = 7'b1000001;
   localparam logic [7:1] SEG_D = 7'b0100001;

   logic clock;
   logic reset_a;
   logic reset_b;

   int n_checks;
   int n_fails;

   updown_counter_n_if #(.WIDTH(4)) ifa ();
   updown_counter_n_if #(.WIDTH(4)) ifb ();

   // Modulus-10 counter
   updown_counter_n #(.WIDTH(4), .MAX_VAL(9)) dut_a (
      .clock (clock),
      .reset (reset_a),
      .bus   (ifa.slave)
   );

   // Default parameters: full 4-bit range
   updown_counter_n #(.WIDTH(4)) dut_b (
      .clock (clock),
      .reset (reset_b),
      .bus   (ifb.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;

      reset_a = 1'b0;
      reset_b = 1'b0;
      ifa.i_en = 1'b0; ifa.i_updown = 1'b1; ifa.i_load = 1'b0;
      ifa.i_load_val = 4'h0; ifa.i_sat_mode = 1'b0;
      ifb.i_en = 1'b0; ifb.i_updown = 1'b1; ifb.i_load = 1'b0;
      ifb.i_load_val = 4'h0; ifb.i_sat_mode = 1'b0;

      // Reset state
      step();
      check("rst_count", 32'(ifa.o_count), 32'd0);
      check("rst_tc",    32'(ifa.o_tc),    32'd0);
      check("rst_dp",    32'(ifa.o_dp),    32'd1);
      check("rst_seg",   32'(ifa.o_seg),   32'(SEG_U));

      // Up count 1..9 then wrap to 0 with tc
      reset_a = 1'b1;
      ifa.i_en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         check($sformatf("up_count_%0d", i), 32'(ifa.o_count), 32'(i % 10));
         check($sformatf("up_tc_%0d", i),    32'(ifa.o_tc),    32'(i == 10));
      end

      // Down wrap 0 -> 9
      ifa.i_updown = 1'b0;
      step();
      check("dn_wrap_count", 32'(ifa.o_count), 32'd9);
      check("dn_wrap_tc",    32'(ifa.o_tc),    32'd1);
      check("dn_wrap_seg",   32'(ifa.o_seg),   32'(SEG_D));
      ifa.i_en = 1'b0;
      step();
      check("dn_tc_drop", 32'(ifa.o_tc),    32'd0);
      check("dn_hold",    32'(ifa.o_count), 32'd9);

      // Saturate at 9 going up
      ifa.i_sat_mode = 1'b1;
      ifa.i_updown   = 1'b1;
      ifa.i_en       = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("sat_count_%0d", i), 32'(ifa.o_count), 32'd9);
         check($sformatf("sat_tc_%0d", i),    32'(ifa.o_tc),    32'd0);
         check($sformatf("sat_dp_%0d", i),    32'(ifa.o_dp),    32'd0);
      end
      ifa.i_updown = 1'b0;
      step();
      check("sat_exit_count", 32'(ifa.o_count), 32'd8);
      check("sat_exit_dp",    32'(ifa.o_dp),    32'd1);

      // Load clamp: 0xC -> 9, load beats enable
      ifa.i_sat_mode = 1'b0;
      ifa.i_updown   = 1'b1;
      ifa.i_load     = 1'b1;
      ifa.i_load_val = 4'hC;
      step();
      check("load_clamp_count", 32'(ifa.o_count), 32'd9);
      check("load_clamp_tc",    32'(ifa.o_tc),    32'd0);

      // Load at the wrap boundary: load wins, no tc
      ifa.i_load_val = 4'h3;
      step();
      check("load_prio_count", 32'(ifa.o_count), 32'd3);
      check("load_prio_tc",    32'(ifa.o_tc),    32'd0);

      // Enable off, toggling direction: count frozen, glyph follows
      ifa.i_load = 1'b0;
      ifa.i_en   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ifa.i_updown = i[0];
         step();
         check($sformatf("tog_count_%0d", i), 32'(ifa.o_count), 32'd3);
         check($sformatf("tog_seg_%0d", i),   32'(ifa.o_seg),   (i[0] ? 32'(SEG_U) : 32'(SEG_D)));
      end

      // dp holds while disabled and across a sat_mode change
      ifa.i_load     = 1'b1;
      ifa.i_load_val = 4'h9;
      step();
      ifa.i_load     = 1'b0;
      ifa.i_sat_mode = 1'b1;
      ifa.i_updown   = 1'b1;
      ifa.i_en       = 1'b1;
      step();
      check("dp_set_count", 32'(ifa.o_count), 32'd9);
      check("dp_set",       32'(ifa.o_dp),    32'd0);
      ifa.i_en = 1'b0;
      step();
      check("dp_hold_en0", 32'(ifa.o_dp), 32'd0);
      ifa.i_sat_mode = 1'b0;
      step();
      check("dp_hold_mode", 32'(ifa.o_dp), 32'd0);
      ifa.i_en     = 1'b1;
      ifa.i_updown = 1'b0;
      step();
      check("dp_clr_count", 32'(ifa.o_count), 32'd8);
      check("dp_clr",       32'(ifa.o_dp),    32'd1);

      // Reset beats load/en/direction
      reset_a        = 1'b0;
      ifa.i_load     = 1'b1;
      ifa.i_load_val = 4'h5;
      step();
      check("midrst_count", 32'(ifa.o_count), 32'd0);
      check("midrst_tc",    32'(ifa.o_tc),    32'd0);
      check("midrst_dp",    32'(ifa.o_dp),    32'd1);
      check("midrst_seg",   32'(ifa.o_seg),   32'(SEG_U));

      // Default-parameter counter: full-range wrap
      reset_b        = 1'b1;
      ifb.i_load     = 1'b1;
      ifb.i_load_val = 4'hE;
      step();
      check("b_load14", 32'(ifb.o_count), 32'd14);
      ifb.i_load = 1'b0;
      ifb.i_en   = 1'b1;
      step();
      check("b_count15", 32'(ifb.o_count), 32'd15);
      check("b_tc15",    32'(ifb.o_tc),    32'd0);
      step();
      check("b_wrap_count", 32'(ifb.o_count), 32'd0);
      check("b_wrap_tc",    32'(ifb.o_tc),    32'd1);

      // tc period is MAX_VAL+1 = 16 cycles
      for (int i = 1; i <= 16; i++) begin
         step();
         check($sformatf("b_per_count_%0d", i), 32'(ifb.o_count), 32'(i % 16));
         check($sformatf("b_per_tc_%0d", i),    32'(ifb.o_tc),    32'(i == 16));
      end

      // Reset on the same edge as a wrap
      ifb.i_load     = 1'b1;
      ifb.i_load_val = 4'hF;
      step();
      check("b_load15", 32'(ifb.o_count), 32'd15);
      ifb.i_load = 1'b0;
      reset_b    = 1'b0;
      step();
      check("b_rstwrap_count", 32'(ifb.o_count), 32'd0);
      check("b_rstwrap_tc",    32'(ifb.o_tc),    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable, and wrap or saturate overflow mode. A registered 7-segment glyph shows the current direction. A terminal-count pulse and a saturation indicator let the count cascade or drive board LEDs. It sits between the board switch/button inputs and the LED/7-segment outputs of the lab top level, and serves as the reusable counter for later exercises.

## Interface
- WIDTH, default 4: counter width in bits, range 2..16.
- MAX_VAL, default 2**WIDTH-1: highest count value; the count range is 0..MAX_VAL, and MAX_VAL must be at least 1.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low; clock is clock.
- en  in  1  count enable; when 0, no step occurs.
- updown  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous parallel load request.
- load_val  in  WIDTH  value to load.
- sat_mode  in  1  overflow mode: 0 = wrap, 1 = saturate.
- count  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, one cycle wide.
- seg  out  7  direction glyph, active-low; seg[1..7] = segments a..g.
- dp  out  1  saturation indicator, active-low.

## Operation
- Priority per clock edge: reset, then load, then en step, then hold.
- Reset (reset==0): count=0, tc=0, dp=1, seg=7'b1000001 (glyph "U").
- Load (load==1): count ← min(load_val, MAX_VAL). tc=0 and dp=1. load overrides en and the direction.
- Up step (en==1, updown==1):
  - count<MAX_VAL: count+1.
  - count==MAX_VAL and sat_mode==0: count ← 0, tc=1.
  - count==MAX_VAL and sat_mode==1: count holds, tc=0, dp=0.
- Down step (en==1, updown==0):
  - count>0: count−1.
  - count==0 and sat_mode==0: count ← MAX_VAL, tc=1.
  - count==0 and sat_mode==1: count holds, tc=0, dp=0.
- tc is 1 only in the cycle following a wrap edge. Any other edge registers tc=0.
- dp:
  - Cleared to 0 by a blocked saturating step.
  - Set back to 1 by any successful step, a load, or a reset.
  - Holds its value while en==0.
- Arithmetic:
  - Comparisons are against MAX_VAL, not 2**WIDTH-1.
  - No intermediate value may exceed WIDTH bits.
  - count never leaves 0..MAX_VAL.
- seg is registered every cycle from updown, independent of en and load:
  - updown=1: "U", segments b,c,d,e,f lit = 7'b1000001 (bit order g..a).
  - updown=0: "d", segments b,c,d,e,g lit = 7'b0100001.
- Changing direction mid-count is legal. The next enabled step uses the new direction with no dead cycle.
- Changing sat_mode takes effect at the next edge. An existing dp=0 persists until the next clearing event.

## Timing
- All outputs are registers; there is no combinational path from input to output.
- Latency is one clock from an input change to the count, tc, dp, or seg update.
- In wrap mode with en held at 1, tc has a period of MAX_VAL+1 cycles.
- Reset asserted mid-count clears all state on that edge, regardless of load, en, or updown.
- A load and a boundary condition on the same edge: the load wins, and no tc or dp event occurs.

## Test plan
- Reset and up count, WIDTH=4, MAX_VAL=9, wrap, en=1, up:
  - Reset → count=0, seg=7'b1000001, dp=1.
  - Then 10 edges → count 1..9, 0.
  - tc=1 only in the cycle count shows 0 after 9.
- Down wrap, MAX_VAL=9: from count=0, updown=0 → count=9, tc=1 for one cycle, seg=7'b0100001.
- Saturate, MAX_VAL=9, sat_mode=1:
  - From count=9, up, 3 edges → count stays 9, tc=0, dp=0.
  - Next: updown=0, one edge → count=8, dp=1.
- Load clamp and priority, MAX_VAL=9:
  - load=1, load_val=4'hC, en=1 → count=9.
  - load=1 with count=9, up, wrap mode → count=load_val, tc=0.
- Enable and direction toggling: en=0 for 5 cycles while toggling updown → count constant, seg follows updown one cycle later.
- Default parameters (WIDTH=4, MAX_VAL=15), wrap:
  - count=15, up → count=0, tc=1.
  - Reset asserted on the same edge as a wrap → count=0, tc=0.
